// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed multiply / divide unit.
//   MULT: radix-2 Booth, WIDTH iterations, 2*WIDTH-bit product in {HI,LO}.
//   DIV : restoring division on magnitudes, WIDTH iterations,
//         quotient in LO, remainder in HI (remainder takes the dividend's sign).
//         A zero divisor is flagged one cycle after the start and HI/LO are left alone.
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   mult_start, div_start one-cycle start pulses (mult wins if both are high)
//   A, B                  operands, captured on the accepting edge
//   HI, LO                result registers, updated only on the done edge
//   busy                  operation in progress
//   done                  one-cycle pulse when HI/LO update or a div-by-zero is reported
//   div_zero              sticky flag for a DIV with B==0, cleared by the next accepted start
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t           state_q;
  logic [2*WIDTH:0] acc_q;      // Booth accumulator {upper, multiplier, q-1}
  logic [WIDTH-1:0] opb_q;      // multiplicand (MULT) or divisor magnitude (DIV)
  logic [WIDTH-1:0] rem_q, quo_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, dz_q, neg_q_q, neg_r_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, div_zero_q;

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

  // Booth step. The add/subtract is done one bit wider than the upper half so
  // that a -2^(W-1) multiplicand cannot overflow; the extra sign bit is what
  // gets shifted back into the accumulator.
  logic [WIDTH:0]   upper_x, mcand_x, booth_sum;
  logic [2*WIDTH:0] acc_d;
  always_comb begin
    upper_x = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    mcand_x = {opb_q[WIDTH-1], opb_q};
    case (acc_q[1:0])
      2'b01:   booth_sum = upper_x + mcand_x;
      2'b10:   booth_sum = upper_x - mcand_x;
      default: booth_sum = upper_x;
    endcase
    acc_d = {booth_sum, acc_q[WIDTH:1]};
  end

  // Restoring division step. The shifted partial remainder is WIDTH+1 bits;
  // when the trial subtract succeeds the result is always below the divisor,
  // so a WIDTH-bit subtract is exact.
  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] sub, rem_d, quo_d;
  logic             ge;
  always_comb begin
    rs    = {rem_q, quo_q[WIDTH-1]};
    ge    = (rs >= {1'b0, opb_q});
    sub   = rs[WIDTH-1:0] - opb_q;
    rem_d = ge ? sub : rs[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], ge};
  end

  // Magnitudes; -2^(W-1) maps to 2^(W-1), which fits as unsigned.
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = A[WIDTH-1] ? -A : A;
  assign abs_b = B[WIDTH-1] ? -B : B;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      opb_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mult_start || div_start) begin
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            dz_q       <= 1'b0;
            cnt_q      <= CW'(WIDTH);
            if (mult_start) begin
              is_div_q <= 1'b0;
              opb_q    <= A;
              acc_q    <= {{WIDTH{1'b0}}, B, 1'b0};
              state_q  <= MULT;
            end else if (B == '0) begin
              // No iterations: report on the next edge, HI/LO untouched.
              is_div_q <= 1'b1;
              dz_q     <= 1'b1;
              state_q  <= FINISH;
            end else begin
              is_div_q <= 1'b1;
              opb_q    <= abs_b;
              quo_q    <= abs_a;
              rem_q    <= '0;
              neg_q_q  <= A[WIDTH-1] ^ B[WIDTH-1];
              neg_r_q  <= A[WIDTH-1];
              state_q  <= DIV;
            end
          end
        end
        MULT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FINISH;
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FINISH;
        end
        FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
          if (dz_q) begin
            div_zero_q <= 1'b1;
          end else if (is_div_q) begin
            lo_q <= neg_q_q ? -quo_q : quo_q;
            hi_q <= neg_r_q ? -rem_q : rem_q;
          end else begin
            hi_q <= acc_q[2*WIDTH:WIDTH+1];
            lo_q <= acc_q[WIDTH:1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32): latency, results, div-by-zero,
// async reset mid-operation, ignored starts while busy, start priority and
// back-to-back starts in the done cycle.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI, LO;
  logic        busy, done, div_zero;

  int vectors = 0;
  int miscompares = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an op at the next negedge (so the following posedge is E0), scramble
  // A/B after E0, wait (bounded) for done and check latency and results.
  // poke>0 pulses div_start with B=0 at that cycle count while busy.
  task automatic run_op(input string tag, input bit ms, input bit ds,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] ehi,
                        input logic [31:0] elo, input bit edz, input int poke);
    int n;
    @(negedge clk);
    A = a; B = b; mult_start = ms; div_start = ds;
    @(posedge clk); #1;
    chk({tag, " busy@E0"}, busy, 1'b1);
    chk({tag, " done@E0"}, done, 1'b0);
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    A = $urandom; B = $urandom;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (poke > 0 && n == poke) begin A = 32'd100; B = 32'd0; div_start = 1'b1; end
      if (poke > 0 && n == poke + 1) div_start = 1'b0;
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " HI"}, HI, ehi);
    chk({tag, " LO"}, LO, elo);
    chk({tag, " busy@done"}, busy, 1'b0);
    chk({tag, " div_zero"}, div_zero, edz);
  endtask

  initial begin
    bit saw_done;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst HI", HI, 32'h0);
    chk("rst LO", LO, 32'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst div_zero", div_zero, 1'b0);
    @(negedge clk); reset = 1'b0;

    // multiplies and divides, each started in the previous op's done cycle
    run_op("mul 6*7",     1, 0, 32'd6,        32'd7,        33, 32'h0,        32'h0000002A, 0, 0);
    run_op("mul -3*5",    1, 0, 32'hFFFFFFFD, 32'd5,        33, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0);
    run_op("mul min*min", 1, 0, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0,        0, 0);
    run_op("div -7/2",    0, 1, 32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
    run_op("div 100/-7",  0, 1, 32'd100,      32'hFFFFFFF9, 33, 32'h2,        32'hFFFFFFF2, 0, 0);
    run_op("div min/-1",  0, 1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0,        32'h80000000, 0, 0);
    run_op("div 10/0",    0, 1, 32'd10,       32'd0,        1,  32'h0,        32'h80000000, 1, 0);
    @(posedge clk); #1;
    chk("dz done one cycle", done, 1'b0);
    chk("dz sticky", div_zero, 1'b1);
    run_op("mul clears dz", 1, 0, 32'd7,      32'hFFFFFFFF, 33, 32'hFFFFFFFF, 32'hFFFFFFF9, 0, 0);
    @(posedge clk); #1;
    chk("done one cycle", done, 1'b0);
    chk("HI/LO hold", LO, 32'hFFFFFFF9);

    // async reset during multiply iteration 10
    @(negedge clk);
    A = 32'd100; B = 32'd100; mult_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); mult_start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst HI", HI, 32'h0);
    chk("midrst LO", LO, 32'h0);
    chk("midrst done", done, 1'b0);
    @(negedge clk); reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("midrst no resume", saw_done, 1'b0);
    chk("midrst LO stays", LO, 32'h0);

    run_op("mul 2*3 after rst", 1, 0, 32'd2, 32'd3, 33, 32'h0, 32'd6, 0, 0);
    // div_start while busy is ignored (B=0 would otherwise raise div_zero)
    run_op("mul 9*9 poked",     1, 0, 32'd9, 32'd9, 33, 32'h0, 32'd81, 0, 5);
    // both starts: multiply wins (a divide would give LO=0, HI=4)
    run_op("both starts",       1, 1, 32'd4, 32'd5, 33, 32'h0, 32'd20, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
